// File: rtl/block_move_ctrl.sv
// Move sequencer for the falling block: merges key presses and gravity into one request at a
// time, proposes a candidate position, and commits or rejects it after the collision check.
module block_move_ctrl #(
    parameter int CELL        = 20,
    parameter int GRAVITY_DIV = 25_000_000,
    parameter int X_START     = 298,
    parameter int Y_START     = 100
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       run,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_down,
    input  logic       key_drop,
    input  logic [9:0] cur_x,
    input  logic [9:0] cur_y,
    input  logic       chk_done,
    input  logic       chk_hit,
    output logic [9:0] cand_x,
    output logic [9:0] cand_y,
    output logic       chk_req,
    output logic       MoveBlock,
    output logic       lock,
    output logic       busy
);

    localparam int               CNT_W   = $clog2(GRAVITY_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GRAVITY_DIV - 1);
    localparam logic [9:0]       STEP    = 10'(CELL);
    localparam logic [9:0]       POS_MAX = 10'(1023 - CELL);
    localparam logic [9:0]       X_RST   = 10'(X_START);
    localparam logic [9:0]       Y_RST   = 10'(Y_START);

    localparam int P_RIGHT = 0;
    localparam int P_LEFT  = 1;
    localparam int P_DOWN  = 2;
    localparam int P_GRAV  = 3;
    localparam int P_DROP  = 4;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_LOCK} state_t;
    typedef enum logic [2:0] {M_DROP, M_GRAV, M_DOWN, M_LEFT, M_RIGHT} mode_t;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [4:0]       pend_q, pend_d;
    logic [3:0]       key_prev_q, key_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       cand_x_q, cand_x_d;
    logic [9:0]       cand_y_q, cand_y_d;
    logic             chk_req_q, chk_req_d;
    logic             move_q, move_d;
    logic             lock_q, lock_d;
    logic             busy_q, busy_d;

    logic [3:0] key_now;
    logic [3:0] key_rise;
    logic [4:0] pend_set;
    logic [4:0] pend_clr;
    logic [4:0] sel_clr;
    logic       sel_valid;
    mode_t      sel_mode;
    logic       grav_tick;
    logic       cnt_clr;
    logic       mode_is_down;

    // Key edges and gravity tick feed the pending flags; a set always beats a same-cycle clear.
    always_comb begin
        key_now    = {key_drop, key_down, key_left, key_right};
        key_rise   = key_now & ~key_prev_q;
        key_prev_d = key_now;
        grav_tick  = run && (cnt_q == CNT_MAX);
        pend_set   = {key_rise[3], grav_tick, key_rise[2], key_rise[1], key_rise[0]};
        pend_d     = (pend_q & ~pend_clr) | pend_set;
        if (!run || cnt_clr || grav_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fixed-priority pick among pending requests: drop > grav > down > left > right.
    always_comb begin
        sel_valid = 1'b1;
        sel_mode  = M_RIGHT;
        sel_clr   = '0;
        if (pend_q[P_DROP]) begin
            sel_mode        = M_DROP;
            sel_clr[P_DROP] = 1'b1;
        end else if (pend_q[P_GRAV]) begin
            sel_mode        = M_GRAV;
            sel_clr[P_GRAV] = 1'b1;
        end else if (pend_q[P_DOWN]) begin
            sel_mode        = M_DOWN;
            sel_clr[P_DOWN] = 1'b1;
        end else if (pend_q[P_LEFT]) begin
            sel_mode        = M_LEFT;
            sel_clr[P_LEFT] = 1'b1;
        end else if (pend_q[P_RIGHT]) begin
            sel_mode         = M_RIGHT;
            sel_clr[P_RIGHT] = 1'b1;
        end else begin
            sel_valid = 1'b0;
        end
    end

    assign mode_is_down = (mode_q != M_LEFT) && (mode_q != M_RIGHT);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        pend_clr = '0;
        cnt_clr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run && sel_valid) begin
                    pend_clr = sel_clr;
                    mode_d   = sel_mode;
                    case (sel_mode)
                        M_LEFT: begin
                            if (cur_x >= STEP) begin
                                cand_x_d = cur_x - STEP;
                                cand_y_d = cur_y;
                                state_d  = S_CHECK;
                            end
                        end
                        M_RIGHT: begin
                            if (cur_x <= POS_MAX) begin
                                cand_x_d = cur_x + STEP;
                                cand_y_d = cur_y;
                                state_d  = S_CHECK;
                            end
                        end
                        default: begin
                            if (cur_y > POS_MAX) begin
                                state_d = S_LOCK;
                            end else begin
                                cand_x_d = cur_x;
                                cand_y_d = cur_y + STEP;
                                state_d  = S_CHECK;
                            end
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (chk_done) begin
                    if (!chk_hit) begin
                        state_d = S_COMMIT;
                    end else if (mode_is_down) begin
                        state_d = S_LOCK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_COMMIT: begin
                // A hard drop keeps stepping from its own last candidate until a step is refused.
                if (mode_q == M_DROP) begin
                    if (cand_y_q > POS_MAX) begin
                        state_d = S_LOCK;
                    end else begin
                        cand_y_d = cand_y_q + STEP;
                        state_d  = S_CHECK;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                pend_clr = '1;
                cnt_clr  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        chk_req_d = (state_d == S_CHECK);
        move_d    = (state_d == S_COMMIT);
        lock_d    = (state_d == S_LOCK);
        busy_d    = (state_d != S_IDLE);
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            mode_q     <= M_DROP;
            pend_q     <= '0;
            key_prev_q <= '0;
            cnt_q      <= '0;
            cand_x_q   <= X_RST;
            cand_y_q   <= Y_RST;
            chk_req_q  <= 1'b0;
            move_q     <= 1'b0;
            lock_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            key_prev_q <= key_prev_d;
            cnt_q      <= cnt_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            chk_req_q  <= chk_req_d;
            move_q     <= move_d;
            lock_q     <= lock_d;
            busy_q     <= busy_d;
        end
    end

    assign cand_x    = cand_x_q;
    assign cand_y    = cand_y_q;
    assign chk_req   = chk_req_q;
    assign MoveBlock = move_q;
    assign lock      = lock_q;
    assign busy      = busy_q;

endmodule

// File: doc/block_move_ctrl.md
# block_move_ctrl

Sequencing controller for the falling-block position register. It merges key presses and a gravity timer into one move request at a time, and proposes a candidate position. It handshakes with the collision checker, then either commits the move with a one-cycle `MoveBlock` pulse to the position register or rejects it. A rejected downward move signals a lock; a hard drop repeats downward steps until one is rejected.

## Interface
- `CELL`, 20: pixel step per move (x and y).
- `GRAVITY_DIV`, 25_000_000: Clk cycles between gravity ticks (≥2).
- `X_START`, 298: reset value of `cand_x`.
- `Y_START`, 100: reset value of `cand_y`.

- `Clk`  in  1  clock.
- `Reset`  in  1  reset, synchronous, active-high.
- `run`  in  1  enables gravity counter and request servicing.
- `key_left`, `key_right`, `key_down`, `key_drop`  in  1 each  raw key levels, already synchronous to `Clk`.
- `cur_x`, `cur_y`  in  10 each  committed position from the position register.
- `chk_done`  in  1  collision result valid.
- `chk_hit`  in  1  candidate collides; valid only with `chk_done`.
- `cand_x`, `cand_y`  out  10 each  proposed position; drives the position register's load inputs.
- `chk_req`  out  1  collision check requested for `cand_x`/`cand_y`.
- `MoveBlock`  out  1  one-cycle commit pulse.
- `lock`  out  1  one-cycle pulse: piece has landed.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **Edge detection:** each key has a previous-value register, reset to 0. A rising edge sets the key's pending flag. A key held through reset therefore produces an edge on the first cycle after reset.
- **Gravity:** the counter runs 0..GRAVITY_DIV-1 while `run`=1 and wraps. When it reaches GRAVITY_DIV-1, it sets `grav_pend`. When `run`=0, the counter is held at 0.
- **Pending flags:** one flag each for drop, grav, down, left and right.
  - A repeat edge on an already-set flag merges into the single pending request.
  - If a set and a clear hit the same flag in the same cycle, the set wins.
- **Priority in IDLE:** drop > grav > down > left > right. The highest set flag is serviced when `run`=1, and its flag is cleared.
- **Candidate computation:** the selected move is latched in a mode register.
  - Down, grav and drop: `cand_y`=`cur_y`+CELL, `cand_x`=`cur_x`.
  - Left: `cand_x`=`cur_x`-CELL. Right: `cand_x`=`cur_x`+CELL.
  - Arithmetic is 10-bit unsigned.
- **Boundary discards:** these requests skip the collision check.
  - Left with `cur_x` < CELL: discarded, stay in IDLE, no pulse.
  - Right with `cur_x` > 1023-CELL: discarded the same way.
  - Downward move with `cur_y` > 1023-CELL: go to LOCK.
- **State machine:**
  - IDLE: when a request is selected, go to CHECK. Otherwise stay.
  - CHECK: `chk_req`=1 until `chk_done`. `cand_x`/`cand_y` are stable throughout.
    - `chk_hit`=0: go to COMMIT.
    - `chk_hit`=1 and the mode is down, grav or drop: go to LOCK.
    - `chk_hit`=1 and the mode is left or right: go to IDLE with no pulse.
  - COMMIT: `MoveBlock`=1 for exactly this cycle.
    - Mode drop: `cand_y`+=CELL, with the same boundary rule, then go to CHECK.
    - Otherwise: go to IDLE.
  - LOCK: `lock`=1 for exactly this cycle. Clear all pending flags and the gravity counter, then go to IDLE.
- **Run deasserted mid-operation:** a sequence already started completes. No new request is selected while `run`=0, and pending flags are retained.
- **Reset values:**
  - Outputs: `chk_req`=0, `MoveBlock`=0, `lock`=0, `busy`=0, `cand_x`=X_START, `cand_y`=Y_START.
  - Internal: state IDLE, all pending flags 0, counter 0.
  - Reset mid-CHECK abandons the check; a late `chk_done` in IDLE is ignored.

## Timing
- Key edge at cycle N: pending flag set at N+1, selected at N+1 if IDLE.
- Candidate registered and `chk_req` high from N+2.
- `chk_done` at cycle C gives `MoveBlock` or `lock` at C+1 and IDLE at C+2.
- Minimum single-move latency, key edge to `MoveBlock`, is 3 cycles when `chk_done` is returned in the first CHECK cycle.
- Hard drop costs at least 2 cycles per row: CHECK then COMMIT.
- All outputs are registered. `MoveBlock` and `lock` are never high together.

## Test plan
- **Reset:** assert `Reset` mid-CHECK -> next cycle `cand_x`=298, `cand_y`=100, all pulses 0, `busy`=0.
- **Lateral move:** `cur_x`=298, `key_right` edge, checker returns `chk_done`=1, `chk_hit`=0 immediately -> `cand_x`=318, one `MoveBlock` pulse 3 cycles after the edge.
- **Boundary and lateral reject:** `cur_x`=10, `key_left` edge -> no `chk_req`, no pulse. `cur_x`=298 with `chk_hit`=1 -> no pulse, no lock.
- **Gravity and lock:** GRAVITY_DIV=8, `run`=1 -> grav request every 8 cycles, `cand_y`=`cur_y`+20. With `chk_hit`=1 -> single `lock` pulse and counter restarts at 0.
- **Priority:** `key_left`, `key_down` and `key_drop` edges in the same cycle -> drop serviced first. Lock clears the others, so there is exactly one lock and no lateral move.
- **Hard drop:** `cur_y`=100, checker hits on the 4th check -> 3 `MoveBlock` pulses with `cand_y`=120, 140, 160, then `lock`. A late `chk_done` in IDLE is ignored.
